// File: rtl/tmds_encoder_dc_pkg.sv
// tmds_encoder_dc_pkg: DVI 1.0 TMDS control tokens and shared helpers
package tmds_encoder_dc_pkg;

  localparam logic [9:0] TMDS_CTRL_00   = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01   = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10   = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11   = 10'b1010101011;
  localparam logic [9:0] TMDS_RESET_SYM = TMDS_CTRL_00;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    return c == 2'b00 ? TMDS_CTRL_00 :
           c == 2'b01 ? TMDS_CTRL_01 :
           c == 2'b10 ? TMDS_CTRL_10 : TMDS_CTRL_11;
  endfunction

endpackage

// File: rtl/tmds_encoder_dc_qm_stage.sv
// tmds_qm_stage: transition-minimising first stage of the TMDS encoder
module tmds_qm_stage
  import tmds_encoder_dc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  output logic [8:0] q_m,
  output logic       de_s1,
  output logic [1:0] ctrl_s1
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_c;

  // chain each data bit onto the previous code bit, XNOR when many ones
  function automatic logic [8:0] chain(input logic [7:0] d, input logic x);
    logic [8:0] q;
    q = 9'd0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = ~x;
    return q;
  endfunction

  // choose XOR/XNOR from the ones count of the pixel
  always_comb begin
    n1d      = popcount8(din);
    use_xnor = (n1d > 4'd4) | ((n1d == 4'd4) & ~din[0]);
    q_m_c    = chain(din, use_xnor);
  end

  // register the intermediate word alongside its de/ctrl qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m     <= 9'd0;
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
    end else begin
      q_m     <= q_m_c;
      de_s1   <= de;
      ctrl_s1 <= ctrl;
    end
  end

endmodule

// File: rtl/tmds_encoder_dc.sv
// tmds_encoder_dc: DVI TMDS channel encoder with running-disparity DC balance
module tmds_encoder_dc
  import tmds_encoder_dc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       de,
  input  logic [7:0] din,
  input  logic [1:0] ctrl,
  output logic [9:0] tdout
);

  logic [8:0]        q_m;
  logic              de_s1;
  logic [1:0]        ctrl_s1;
  logic [3:0]        n1q;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_nxt;
  logic signed [4:0] bal;
  logic signed [4:0] two_q8;
  logic signed [4:0] two_nq8;
  logic              case_a;
  logic              case_b;
  logic [9:0]        sym;

  tmds_qm_stage u_qm (
    .clk     (clk),
    .rst_n   (rst_n),
    .de      (de),
    .din     (din),
    .ctrl    (ctrl),
    .q_m     (q_m),
    .de_s1   (de_s1),
    .ctrl_s1 (ctrl_s1)
  );

  // pick inversion so the running disparity is pulled back toward zero
  always_comb begin
    n1q     = popcount8(q_m[7:0]);
    bal     = $signed({n1q, 1'b0} - 5'd8);
    two_q8  = $signed({3'b000, q_m[8], 1'b0});
    two_nq8 = $signed({3'b000, ~q_m[8], 1'b0});
    case_a  = (cnt == 5'sd0) | (bal == 5'sd0);
    case_b  = ((cnt > 5'sd0) & (bal > 5'sd0)) | ((cnt < 5'sd0) & (bal < 5'sd0));
    sym     = ctrl_token(ctrl_s1);
    cnt_nxt = 5'sd0;
    if (de_s1 && case_a) begin
      sym     = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
      cnt_nxt = q_m[8] ? cnt + bal : cnt - bal;
    end else if (de_s1 && case_b) begin
      sym     = {1'b1, q_m[8], ~q_m[7:0]};
      cnt_nxt = cnt + two_q8 - bal;
    end else if (de_s1) begin
      sym     = {1'b0, q_m[8], q_m[7:0]};
      cnt_nxt = cnt - two_nq8 + bal;
    end
  end

  // output symbol and disparity counter; control periods clear the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdout <= TMDS_RESET_SYM;
      cnt   <= 5'sd0;
    end else begin
      tdout <= sym;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dc.sv
// tb_tmds_encoder_dc: scoreboard bench for the TMDS encoder against a reference model
module tb_tmds_encoder_dc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       de = 1'b0;
  logic [7:0] din = 8'd0;
  logic [1:0] ctrl = 2'b00;
  logic [9:0] tdout;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int mcnt = 0;

  typedef struct {
    int         due;
    logic [9:0] sym;
    bit         data;
    logic [7:0] pix;
  } exp_t;

  exp_t sb[$];
  exp_t me;

  tmds_encoder_dc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .de    (de),
    .din   (din),
    .ctrl  (ctrl),
    .tdout (tdout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecount++;

  function automatic logic [9:0] token(input logic [1:0] c);
    case (c)
      2'b00:   return 10'h354;
      2'b01:   return 10'h0AB;
      2'b10:   return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // q_m bit i is the parity of din[0..i], flipped on odd bits when XNOR is used;
  // disparity is tracked as ones minus zeros of every emitted symbol
  function automatic logic [9:0] model(input logic d_e, input logic [7:0] d, input logic [1:0] c);
    logic [8:0] qm;
    logic [9:0] s;
    int ones, bal;
    bit xn, inv;
    if (!d_e) begin
      mcnt = 0;
      return token(c);
    end
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    for (int i = 0; i < 8; i++) qm[i] = (^(d & 8'((1 << (i + 1)) - 1))) ^ (xn && (i % 2 == 1));
    qm[8] = !xn;
    bal = 2 * $countones(qm[7:0]) - 8;
    if (mcnt == 0 || bal == 0) inv = !qm[8];
    else inv = ((mcnt > 0) == (bal > 0));
    s = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
    mcnt += 2 * $countones(s) - 10;
    return s;
  endfunction

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] d, o;
    d = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input int due, input logic [9:0] s);
    exp_t e;
    e.due = due; e.sym = s; e.data = 1'b0; e.pix = 8'd0;
    sb.push_back(e);
  endtask

  task automatic drive(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                       input bit use_k, input logic [9:0] k);
    exp_t e;
    logic [9:0] m;
    @(negedge clk);
    de = d_e; din = d; ctrl = c;
    m = model(d_e, d, c);
    e.due = ecount + 2;
    e.sym = use_k ? k : m;
    e.data = d_e;
    e.pix = d;
    sb.push_back(e);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push(ecount + 1, 10'h354);
    push(ecount + 2, 10'h354);
  endtask

  // monitor: one symbol per clock, popped and compared when its slot arrives
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due <= ecount) begin
      me = sb.pop_front();
      checks++;
      if (me.due != ecount || tdout !== me.sym) begin
        errors++;
        $display("FAIL sym slot=%0d now=%0d got=%h exp=%h", me.due, ecount, tdout, me.sym);
      end
      if (me.data) begin
        checks++;
        if (decode(tdout) !== me.pix) begin
          errors++;
          $display("FAIL decode got=%h exp=%h", decode(tdout), me.pix);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_sym", tdout, 10'h354);
    release_reset();
    drive(1'b0, 8'($urandom), 2'b00, 1, 10'h354);
    drive(1'b0, 8'($urandom), 2'b01, 1, 10'h0AB);
    drive(1'b0, 8'($urandom), 2'b10, 1, 10'h154);
    drive(1'b0, 8'($urandom), 2'b11, 1, 10'h2AB);
    drive(1'b1, 8'h00, 2'($urandom), 1, 10'h100);
    drive(1'b1, 8'h00, 2'($urandom), 1, 10'h3FF);
    drive(1'b1, 8'h00, 2'($urandom), 1, 10'h100);
    drive(1'b0, 8'h00, 2'b00, 0, 10'h000);
    drive(1'b1, 8'hFF, 2'b11, 1, 10'h200);
    drive(1'b0, 8'h00, 2'b01, 0, 10'h000);
    drive(1'b1, 8'h55, 2'b00, 1, 10'h133);
    drive(1'b0, 8'h00, 2'b00, 0, 10'h000);
    drive(1'b1, 8'hAA, 2'b00, 1, 10'h233);
    drive(1'b0, 8'h00, 2'b10, 0, 10'h000);
    for (int i = 0; i < 1344; i++) drive(1'b1, 8'($urandom), 2'($urandom), 0, 10'h000);
    for (int i = 0; i < 4; i++) drive(1'b0, 8'($urandom), 2'($urandom), 0, 10'h000);
    for (int i = 0; i < 21; i++) drive(1'b1, 8'($urandom), 2'($urandom), 0, 10'h000);
    @(negedge clk);
    #2;
    rst_n = 1'b0; de = 1'b0; ctrl = 2'b00; din = 8'd0;
    #1 chk("async_reset", tdout, 10'h354);
    sb.delete();
    mcnt = 0;
    @(posedge clk);
    #2 chk("reset_hold", tdout, 10'h354);
    release_reset();
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 0, 10'h000);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_dc.md
Name: tmds_encoder_dc

Overview:
- DVI 1.0 TMDS encoder for one colour channel, with DC balancing.
- Sits directly downstream of the display controller and colour-width adjust. It takes 8-bit board colour, display enable and 2 control bits, and produces a 10-bit TMDS symbol for the serialiser.
- Three instances, one per channel, form the parallel front half of the DVI output path. Channel 0 carries {vsync, hsync} as control; channels 1 and 2 carry 2'b00.
- The running disparity counter is the block's state.

Parameters:
- none. Symbol width (10), data width (8) and control tokens are fixed by DVI 1.0.

Ports:
- clk     input   1   pixel clock
- rst_n   input   1   reset, asynchronous, active-low
- de      input   1   display enable; 1 = encode din, 0 = emit control token
- din     input   8   pixel colour data, sampled when de=1
- ctrl    input   2   control bits {c1,c0}, sampled when de=0
- tdout   output  10  TMDS symbol, bit 0 transmitted first

Interface decided: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, async):
  - tdout = 10'b1101010100 (0x354, the ctrl=00 token).
  - cnt = 0.
  - All pipeline registers = 0.
  - Release is synchronous to clk; the first valid output appears 2 cycles after the first sampled input.
- Pipeline: fixed 2-cycle latency, no stalls, one symbol per clock. Input sampled at edge N gives tdout valid after edge N+2.
- Stage 1 (register q_m[8:0], de_s1, ctrl_s1):
  - n1d = popcount(din).
  - use_xnor = (n1d>4) | (n1d==4 & din[0]==0).
  - q_m[0] = din[0].
  - q_m[i] = use_xnor ? ~(q_m[i-1]^din[i]) : (q_m[i-1]^din[i]), for i = 1..7.
  - q_m[8] = ~use_xnor.
- Stage 2 (register tdout, cnt):
  - n1q = popcount(q_m[7:0]); n0q = 8 - n1q.
  - Differences are computed as signed 5-bit values.
- Stage 2, case de_s1=0:
  - tdout = token(ctrl_s1):
    - 00 -> 1101010100
    - 01 -> 0010101011
    - 10 -> 0101010100
    - 11 -> 1010101011
  - cnt <= 0.
- Stage 2, case A, de_s1=1 and (cnt==0 | n1q==n0q):
  - tdout = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
  - cnt += q_m[8] ? (n1q-n0q) : (n0q-n1q).
- Stage 2, case B, de_s1=1 and ((cnt>0 & n1q>n0q) | (cnt<0 & n0q>n1q)):
  - tdout = {1, q_m[8], ~q_m[7:0]}.
  - cnt += 2*q_m[8] + (n0q-n1q).
- Stage 2, case C, de_s1=1, otherwise:
  - tdout = {0, q_m[8], q_m[7:0]}.
  - cnt += -2*(~q_m[8]) + (n1q-n0q).
- cnt width and invariants:
  - 5-bit signed, two's complement.
  - Invariant: cnt is always even and within -10..+10. Overflow is impossible; no saturation logic.
- de transitions:
  - 1->0: cnt clears on the first control symbol.
  - 0->1: encoding starts with cnt=0.
  - de and ctrl are pipelined with data, so the symbol boundary follows the input boundary exactly 2 cycles later.
- ctrl is ignored while de=1; din is ignored while de=0.
- Reset mid-frame: immediate async return to the reset state. After release, the output is token(00) until new inputs propagate through the pipeline.

Decomposition:
- Shared include/package (tmds_defs): TMDS_CTRL_00/01/10/11 token constants and TMDS_RESET_SYM.
- Popcount is a local function.
- Natural sub-module: tmds_qm_stage (stage 1 transition-minimising logic plus its registers). Stage 2 disparity logic stays in tmds_encoder_dc.

Test Plan:
- Reset, then de=0 with ctrl 00/01/10/11 on consecutive cycles -> tdout = 0x354, 0x0AB, 0x154, 0x2AB, starting 2 cycles later; cnt stays 0.
- From cnt=0, de=1, din=0x00 three times -> tdout 0x100, 0x3FF, 0x100; cnt -8, +2, -6.
- From cnt=0, de=1, din=0xFF -> q_m=0x0FF (XNOR path), tdout=0x200, cnt=-8.
- de=1 for 1344 random pixels, then de=0 -> every data symbol decodes (reference decoder) back to din; cnt stays even and within ±10; first control symbol correct; cnt=0 afterwards.
- rst_n asserted mid-line with cnt≠0 -> tdout=0x354 and cnt=0 immediately (asynchronous, not waiting for clk); after release, correct encoding resumes with latency 2.
- din=0x55 and 0xAA at cnt=0 (n1d=4 tie on din[0]) -> XNOR chosen for 0xAA, XOR for 0x55; tdout matches the golden model.
